lector_ram_audio: RTL and testbench

- Downstream consumer of the RAM address walker. Once per habilitador phase it reads one 8-bit audio sample from the external asynchronous PSRAM.
- The falling phase reads the song address; the rising phase reads the effect address.
- It mixes the two samples with saturation and drives a PWM audio output.
- Runs on the 50 MHz system clock. habilitador (~88.2 kHz) is treated as an asynchronous strobe.

---
 rtl/lector_ram_audio_if.sv | 21 ++
 rtl/lector_ram_audio.sv | 165 ++++++++++++++++
 tb/tb_lector_ram_audio.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/lector_ram_audio_if.sv
// Asynchronous PSRAM read bus between the audio reader and the external device.
interface lector_ram_audio_if;
    logic [22:0] ram_addr;
    logic [15:0] ram_dq;
    logic        ram_ce_n;
    logic        ram_oe_n;
    logic        ram_we_n;
    logic        ram_adv_n;
    logic        ram_ub_n;
    logic        ram_lb_n;

    modport master (
        output ram_addr, ram_ce_n, ram_oe_n, ram_we_n, ram_adv_n, ram_ub_n, ram_lb_n,
        input  ram_dq
    );

    modport slave (
        input  ram_addr, ram_ce_n, ram_oe_n, ram_we_n, ram_adv_n, ram_ub_n, ram_lb_n,
        output ram_dq
    );
endinterface

// File: rtl/lector_ram_audio.sv
// Reads one PSRAM audio byte per habilitador phase (song / effect), mixes with saturation, drives PWM.
// state   | meaning
// REPOSO  | idle, waits for a pending phase request
// PREPARA | address and chip enable applied, output enable still high
// LEER    | output enable low for LEER_CICLOS clocks
// CAPTURA | byte captured, bus released
// MEZCLA  | saturated mix registered into muestra
module lector_ram_audio #(
    parameter int unsigned LEER_CICLOS = 5,
    parameter logic [7:0]  SILENCIO    = 8'h80
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      habilitador,
    input  logic [25:0]               direccion_ram,
    input  logic                      enable,
    lector_ram_audio_if.master        ram,
    output logic                      audio_pwm,
    output logic [7:0]                muestra
);
    localparam int unsigned EW = $clog2(LEER_CICLOS + 1);

    typedef enum logic [2:0] {REPOSO, PREPARA, LEER, CAPTURA, MEZCLA} estado_t;

    estado_t        estado_q;
    logic [22:0]    ram_addr_q;
    logic           ce_n_q, oe_n_q;
    logic [EW-1:0]  espera_q;
    logic           dir_lsb_q, fase_lat_q;

    logic           sync1_q, sync2_q, dly_q, pendiente_q, fase_q, en_prev_q, pwm_q;
    logic           sync1_d, sync2_d, dly_d, pendiente_d, fase_d, en_prev_d, pwm_d;
    logic [7:0]     cancion_q, efecto_q, muestra_q, contador_q, cmp_q;
    logic [7:0]     cancion_d, efecto_d, muestra_d, contador_d, cmp_d;

    logic           flanco, pend_eff, fase_eff, servicio, captura, en_rise, efecto_idle;
    logic [7:0]     byte_leido, mezcla;
    logic signed [9:0] suma;

    always_comb begin
        sync1_d     = habilitador;
        sync2_d     = sync1_q;
        dly_d       = sync2_q;
        flanco      = sync2_q ^ dly_q;
        pend_eff    = pendiente_q | flanco;
        fase_eff    = flanco ? sync2_q : fase_q;
        servicio    = (estado_q == REPOSO) && pend_eff;
        pendiente_d = pend_eff && !servicio;
        fase_d      = fase_eff;
        efecto_idle = servicio && fase_eff && (direccion_ram == 26'd0);

        en_prev_d   = enable;
        en_rise     = enable && !en_prev_q;

        captura     = (estado_q == LEER) && (espera_q == '0);
        byte_leido  = dir_lsb_q ? ram.ram_dq[7:0] : ram.ram_dq[15:8];

        cancion_d = cancion_q;
        efecto_d  = efecto_q;
        if (en_rise) begin
            cancion_d = SILENCIO;
            efecto_d  = SILENCIO;
        end else if (efecto_idle) begin
            efecto_d  = SILENCIO;
        end else if (captura) begin
            if (fase_lat_q) efecto_d  = byte_leido;
            else            cancion_d = byte_leido;
        end

        suma = $signed({2'b00, cancion_q}) + $signed({2'b00, efecto_q}) - 10'sd128;
        if (suma < 10'sd0)        mezcla = 8'h00;
        else if (suma > 10'sd255) mezcla = 8'hFF;
        else                      mezcla = suma[7:0];

        muestra_d = muestra_q;
        if (estado_q == MEZCLA) muestra_d = enable ? SILENCIO : mezcla;

        // compare register only reloads at period end so a duty cycle is never split
        contador_d = contador_q + 8'd1;
        cmp_d      = (contador_q == 8'hFF) ? muestra_q : cmp_q;
        pwm_d      = contador_q < cmp_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            dly_q       <= 1'b0;
            pendiente_q <= 1'b0;
            fase_q      <= 1'b0;
            en_prev_q   <= 1'b0;
            cancion_q   <= SILENCIO;
            efecto_q    <= SILENCIO;
            muestra_q   <= SILENCIO;
            contador_q  <= 8'h00;
            cmp_q       <= SILENCIO;
            pwm_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            dly_q       <= dly_d;
            pendiente_q <= pendiente_d;
            fase_q      <= fase_d;
            en_prev_q   <= en_prev_d;
            cancion_q   <= cancion_d;
            efecto_q    <= efecto_d;
            muestra_q   <= muestra_d;
            contador_q  <= contador_d;
            cmp_q       <= cmp_d;
            pwm_q       <= pwm_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= REPOSO;
            ram_addr_q <= '0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            espera_q   <= '0;
            dir_lsb_q  <= 1'b0;
            fase_lat_q <= 1'b0;
        end else begin
            case (estado_q)
                REPOSO: if (pend_eff) begin
                    fase_lat_q <= fase_eff;
                    dir_lsb_q  <= direccion_ram[0];
                    if (fase_eff && (direccion_ram == 26'd0)) begin
                        estado_q <= MEZCLA;
                    end else begin
                        estado_q   <= PREPARA;
                        ram_addr_q <= direccion_ram[23:1];
                        ce_n_q     <= 1'b0;
                        oe_n_q     <= 1'b1;
                    end
                end
                PREPARA: begin
                    estado_q <= LEER;
                    oe_n_q   <= 1'b0;
                    espera_q <= EW'(LEER_CICLOS - 1);
                end
                LEER: if (espera_q == '0) begin
                    estado_q <= CAPTURA;
                    ce_n_q   <= 1'b1;
                    oe_n_q   <= 1'b1;
                end else begin
                    espera_q <= espera_q - EW'(1);
                end
                CAPTURA: estado_q <= MEZCLA;
                MEZCLA:  estado_q <= REPOSO;
                default: estado_q <= REPOSO;
            endcase
        end
    end

    assign ram.ram_addr  = ram_addr_q;
    assign ram.ram_ce_n  = ce_n_q;
    assign ram.ram_oe_n  = oe_n_q;
    assign ram.ram_we_n  = 1'b1;
    assign ram.ram_adv_n = 1'b0;
    assign ram.ram_ub_n  = 1'b0;
    assign ram.ram_lb_n  = 1'b0;
    assign audio_pwm     = pwm_q;
    assign muestra       = muestra_q;
endmodule

// File: tb/tb_lector_ram_audio.sv
// Self-checking bench for lector_ram_audio: PSRAM model, mix reference model, PWM duty monitor.
module tb_lector_ram_audio;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        habilitador;
    logic [25:0] direccion_ram;
    logic        enable;
    logic        audio_pwm;
    logic [7:0]  muestra;

    lector_ram_audio_if ram_bus ();

    lector_ram_audio dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .habilitador   (habilitador),
        .direccion_ram (direccion_ram),
        .enable        (enable),
        .ram           (ram_bus),
        .audio_pwm     (audio_pwm),
        .muestra       (muestra)
    );

    always #10 clk = ~clk;

    logic [15:0] mem [0:255];
    assign ram_bus.ram_dq = (!ram_bus.ram_ce_n && !ram_bus.ram_oe_n) ? mem[ram_bus.ram_addr[7:0]] : 16'hDEAD;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor: cycle count since reset, per-period PWM high count, read log
    int          ncyc = 0, nper = 0, hi = 0;
    int          per_hi [0:63];
    int          ce_pulses = 0, oe_len = 0, oe_len_last = 0;
    logic        prev_oe = 1'b1, prev_ce = 1'b1;
    logic [22:0] addr_log [$];

    initial forever begin
        @(posedge clk);
        #1;
        if (!reset_n) begin
            ncyc = 0; nper = 0; hi = 0;
        end else begin
            ncyc++;
            if (audio_pwm) hi++;
            if (ncyc % 256 == 0) begin
                if (nper < 64) per_hi[nper] = hi;
                nper++;
                hi = 0;
            end
        end
        if (!ram_bus.ram_ce_n && prev_ce) ce_pulses++;
        if (!ram_bus.ram_oe_n && prev_oe) begin
            addr_log.push_back(ram_bus.ram_addr);
            oe_len = 1;
        end else if (!ram_bus.ram_oe_n) begin
            oe_len++;
        end else if (!prev_oe) begin
            oe_len_last = oe_len;
        end
        prev_ce = ram_bus.ram_ce_n;
        prev_oe = ram_bus.ram_oe_n;
    end

    int ref_ca = 128, ref_ef = 128;

    function automatic int mix_ref(input int c, input int e, input logic en);
        int s;
        if (en) return 128;
        s = c + e - 128;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic do_edge(input string tag, input logic [25:0] a, input logic [15:0] d);
        int   ce0, k;
        logic f, rd;
        logic [7:0] b;
        ce0 = ce_pulses;
        mem[a[8:1]] = d;
        @(negedge clk);
        f = ~habilitador;
        direccion_ram = a;
        habilitador = f;
        rd = !(f && (a == 26'd0));
        b = a[0] ? d[7:0] : d[15:8];
        if (!rd)    ref_ef = 128;
        else if (f) ref_ef = b;
        else        ref_ca = b;
        if (rd) begin
            k = 0;
            do begin
                @(posedge clk); #1; k++;
            end while (ram_bus.ram_oe_n && k < 10);
            check_eq({tag, "_lat"}, k, 4);
        end
        repeat (16) @(negedge clk);
        check_eq({tag, "_ce_pulses"}, ce_pulses - ce0, rd ? 1 : 0);
        if (rd) begin
            check_eq({tag, "_addr"}, addr_log[$], a[23:1]);
            check_eq({tag, "_oe_len"}, oe_len_last, 5);
        end
        check_eq({tag, "_muestra"}, muestra, mix_ref(ref_ca, ref_ef, enable));
    endtask

    task automatic wait_periods(input string tag, input int target);
        int g = 0;
        while (nper < target && g < 3000) begin
            @(negedge clk); g++;
        end
        check_eq({tag, "_wait"}, nper >= target, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int p, q, g, ce0, n0, sum;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        reset_n = 1'b0; habilitador = 1'b0; direccion_ram = '0; enable = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ce_n", ram_bus.ram_ce_n, 1);
        check_eq("rst_oe_n", ram_bus.ram_oe_n, 1);
        check_eq("rst_addr", ram_bus.ram_addr, 0);
        check_eq("rst_muestra", muestra, 8'h80);
        check_eq("rst_pwm", audio_pwm, 0);
        check_eq("we_n", ram_bus.ram_we_n, 1);
        check_eq("adv_n", ram_bus.ram_adv_n, 0);
        check_eq("ub_lb_n", {ram_bus.ram_ub_n, ram_bus.ram_lb_n}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        do_edge("idle_ef0", 26'h0000000, 16'h1234);
        do_edge("song_c040", 26'h0000010, 16'hC040);
        do_edge("ef_odd", 26'h0000001, 16'h00A0);
        do_edge("song_odd_sat", 26'h0000011, 16'h11F0);
        check_eq("sat_high", muestra, 8'hFF);
        do_edge("ef_20", 26'h0000002, 16'h2011);
        do_edge("song_10_sat", 26'h0000004, 16'h1055);
        check_eq("sat_low", muestra, 8'h00);
        do_edge("ef_idle", 26'h0000000, 16'hFFFF);
        check_eq("ef_idle_val", muestra, 8'h10);
        do_edge("song_wrap", 26'h2000030, 16'h9000);

        @(negedge clk);
        enable = 1'b1; ref_ca = 128; ref_ef = 128;
        do_edge("pause_ef", 26'h0000006, 16'h7F00);
        check_eq("pause_muestra", muestra, 8'h80);
        p = nper;
        wait_periods("pause", p + 5);
        sum = 0;
        for (int i = 1; i <= 4; i++) sum += per_hi[p + i];
        check_eq("pause_duty", sum, 512);
        check_eq("period0_duty", per_hi[0], 128);

        @(negedge clk);
        enable = 1'b0;
        do_edge("pwm_x", 26'h0000008, 16'h4000);
        check_eq("pwm_x_val", muestra, 8'h3F);
        wait_periods("pwm_x", nper + 2);
        g = 0;
        while ((ncyc % 256) != 100 && g < 600) begin
            @(negedge clk); g++;
        end
        check_eq("pwm_phase_found", (ncyc % 256) == 100, 1);
        q = nper;
        do_edge("pwm_y", 26'h000000A, 16'hC900);
        check_eq("pwm_y_val", muestra, 8'h89);
        wait_periods("pwm_y", q + 2);
        check_eq("duty_mid_period", per_hi[q], 8'h3F);
        check_eq("duty_next_period", per_hi[q + 1], 8'h89);

        ce0 = ce_pulses; n0 = addr_log.size();
        mem[8'h10] = 16'h3300; mem[8'h21] = 16'h9900;
        @(negedge clk);
        direccion_ram = 26'h0000020; habilitador = 1'b0;
        repeat (3) @(negedge clk);
        direccion_ram = 26'h0000042; habilitador = 1'b1;
        ref_ca = 8'h33; ref_ef = 8'h99;
        repeat (30) @(negedge clk);
        check_eq("b2b_ce_pulses", ce_pulses - ce0, 2);
        check_eq("b2b_reads", addr_log.size() - n0, 2);
        if (addr_log.size() == n0 + 2) begin
            check_eq("b2b_first", addr_log[n0], 23'h10);
            check_eq("b2b_second", addr_log[n0 + 1], 23'h21);
        end
        check_eq("b2b_muestra", muestra, mix_ref(ref_ca, ref_ef, enable));

        for (int it = 0; it < 16; it++) begin
            logic [25:0] a;
            logic [15:0] d;
            a = 26'($urandom);
            d = 16'($urandom);
            if (!habilitador && $urandom_range(0, 3) == 0) a = '0;
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                enable = ~enable;
                if (enable) begin ref_ca = 128; ref_ef = 128; end
            end
            do_edge($sformatf("rnd%0d", it), a, d);
        end

        @(negedge clk);
        enable = 1'b0;
        habilitador = ~habilitador;
        direccion_ram = 26'h0000030;
        g = 0;
        while (ram_bus.ram_oe_n && g < 10) begin
            @(posedge clk); #1; g++;
        end
        check_eq("midread_oe_low", ram_bus.ram_oe_n, 0);
        #2;
        reset_n = 1'b0;
        habilitador = 1'b0;
        #1;
        check_eq("midread_rst_ce_n", ram_bus.ram_ce_n, 1);
        check_eq("midread_rst_oe_n", ram_bus.ram_oe_n, 1);
        check_eq("midread_rst_muestra", muestra, 8'h80);
        check_eq("midread_rst_pwm", audio_pwm, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
